divider_8b_4b: RTL and testbench
================================

# divider_8b_4b

Sequential restoring divider that inverts the 4-bit array multiplier: it takes a 2N-bit product-width dividend and an N-bit divisor and returns a 2N-bit quotient and an N-bit remainder. It sits beside the multiplier in the arithmetic library as its inverse operation and also serves as the round-trip checker for multiplier builds. It computes one quotient bit per clock and uses a start/busy/done handshake.

## Interface
- N, default 4: divisor width; dividend and quotient widths are 2N.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while busy=0.
- x  input  2N  dividend; sampled with start.
- y  input  N  divisor; sampled with start.
- busy  output  1  division in progress.
- done  output  1  single-cycle pulse when q/r/dbz are updated.
- q  output  2N  quotient, held until the next completion.
- r  output  N  remainder, held until the next completion.
- dbz  output  1  divide-by-zero flag for the current q/r.

## Operation
- States: IDLE, RUN. The done pulse is registered, not a separate state.
- IDLE with start=1 and y!=0: latch dividend into a 2N shift register, latch divisor, clear the (N+1)-bit partial remainder, set count=2N, go to RUN, busy=1.
- IDLE with start=1 and y==0: do not enter RUN. On the same edge, write q=all ones (255 for N=4), r=0, dbz=1, done=1. busy stays 0.
- RUN step, once per edge:
  - Shift the partial remainder left 1, bringing in the dividend MSB.
  - Subtract the zero-extended divisor.
  - If the result is non-negative, keep it and shift quotient bit 1. Otherwise restore and shift quotient bit 0.
  - Decrement count.
- On the step that brings count to 0: write q, r (low N bits of the partial remainder), dbz=0, done=1, busy=0, and return to IDLE.
- Width rule: the partial remainder is N+1 bits so the compare cannot overflow. The final remainder is always less than y and fits in N bits.
- start while busy=1 is ignored. Held x/y changes during RUN have no effect.
- q/r/dbz change only on an edge that also asserts done.

## Timing
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, q=0, r=0, dbz=0, internal count and registers =0. This takes effect immediately and aborts any division in flight; no done is emitted for the aborted operation.
- Release: the first edge with rst_n=1 may accept start.
- Latency, y!=0:
  - start sampled at edge E0; busy=1 after E0.
  - Steps execute on E1..E2N.
  - After E2N: done=1 for exactly one cycle, busy=0, results valid (E8 for N=4).
- Latency, y==0: after E0, done=1 and dbz=1, with no busy cycle.
- Back-to-back: start may be asserted during the done cycle. It is accepted at that edge (busy=0) and done deasserts at the same edge.
- done never asserts while busy=1. busy and done are never both 1.

## Test plan
- x=195, y=13 -> after 8 edges: q=15, r=0, dbz=0, one-cycle done, busy high for exactly 8 cycles.
- x=200, y=7 -> q=28, r=4; then x=255, y=1 back-to-back in the done cycle -> q=255, r=0 eight edges later.
- x=100, y=0 -> done at the next edge, q=255, r=0, dbz=1, busy never 1. A following x=9, y=3 -> q=3, r=0, dbz=0.
- Start x=50, y=5. Pulse start with x=1, y=1 at cycle 3. Change x/y mid-run. Expected: q=10, r=0, and only one done pulse.
- Start x=240, y=15. Assert rst_n=0 at cycle 4 -> busy/done/q/r/dbz=0 immediately, no done afterward. After release, x=17, y=4 -> q=4, r=1.
- Exhaustive round-trip: for all a,b in 1..15, x=a*b (from multiplier output), y=b -> q=a, r=0. Plus random x in 0..255, y in 1..15 checked against a reference quotient/remainder.

Source files
------------

// File: rtl/divider_8b_4b.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient
// bit per clock, start/busy/done handshake. Divide-by-zero completes at once.
module divider_8b_4b #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*N-1:0] x,
  input  logic [N-1:0]   y,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r,
  output logic           dbz
);

  localparam int unsigned CntW = $clog2(2 * N + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(2 * N);
  localparam logic [CntW-1:0] CntLast = CntW'(1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e         state_q, state_d;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB.
  logic [2*N-1:0] shift_q, shift_d;
  logic [N-1:0]   divisor_q, divisor_d;
  logic [N:0]     rem_q, rem_d;
  logic [CntW-1:0] count_q, count_d;
  logic           done_q, done_d;
  logic           dbz_q, dbz_d;
  logic [2*N-1:0] q_q, q_d;
  logic [N-1:0]   r_q, r_d;

  logic [N+1:0]   rem_wide;
  logic [N+1:0]   diff;

  // Next-state logic: accept, step the restoring loop, and publish results.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    count_d   = count_q;
    done_d    = 1'b0;
    dbz_d     = dbz_q;
    q_d       = q_q;
    r_d       = r_q;

    rem_wide = {rem_q, shift_q[2*N-1]};
    // Extra sign bit makes the trial subtraction overflow-free.
    diff     = rem_wide - {2'b00, divisor_q};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (y != '0) begin
            shift_d   = x;
            divisor_d = y;
            rem_d     = '0;
            count_d   = CntInit;
            state_d   = StRun;
          end else begin
            q_d    = '1;
            r_d    = '0;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (!diff[N+1]) begin
          rem_d   = diff[N:0];
          shift_d = {shift_q[2*N-2:0], 1'b1};
        end else begin
          rem_d   = rem_wide[N:0];
          shift_d = {shift_q[2*N-2:0], 1'b0};
        end
        count_d = count_q - 1'b1;
        if (count_q == CntLast) begin
          state_d = StIdle;
          q_d     = shift_d;
          r_d     = rem_d[N-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any division in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      count_q   <= count_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      q_q       <= q_d;
      r_q       <= r_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = done_q;
  assign dbz  = dbz_q;
  assign q    = q_q;
  assign r    = r_q;

endmodule

// File: tb/tb_divider_8b_4b.sv
// Self-checking bench for divider_8b_4b (N=4) against plain integer division.
module tb_divider_8b_4b;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] x;
  logic [3:0] y;
  logic       busy;
  logic       done;
  logic [7:0] q;
  logic [3:0] r;
  logic       dbz;

  int compared;
  int mismatched;

  divider_8b_4b #(.N(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .x    (x),
    .y    (y),
    .busy (busy),
    .done (done),
    .q    (q),
    .r    (r),
    .dbz  (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the operands.
  function automatic logic [7:0] ref_q(input logic [7:0] a, input logic [3:0] b);
    if (b == 0) return 8'd255;
    return 8'(int'(a) / int'(b));
  endfunction

  function automatic logic [3:0] ref_r(input logic [7:0] a, input logic [3:0] b);
    if (b == 0) return 4'd0;
    return 4'(int'(a) % int'(b));
  endfunction

  // Issue one request at a negedge and wait for done. Returns at the negedge
  // where done=1. lat is the edge index (E0 = accept edge) of the done update.
  task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                        output logic [7:0] oq, output logic [3:0] orr,
                        output logic odbz, output int nbusy, output int lat,
                        output bit both, output bit tmo);
    x = a;
    y = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    lat = -1;
    both = 1'b0;
    tmo = 1'b1;
    oq = '0;
    orr = '0;
    odbz = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (busy && done) both = 1'b1;
      if (busy) nbusy++;
      if (done) begin
        lat = i - 1;
        oq = q;
        orr = r;
        odbz = dbz;
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    x = '0;
    y = '0;
    #1;
    compared++;
    if ({busy, done, q, r, dbz} !== 15'd0) begin
      mismatched++;
      $display("FAIL reset_state: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, q, r, dbz);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] oq; logic [3:0] orr; logic odbz; int nb, lat; bit both, tmo;
    do_div(8'd195, 4'd13, oq, orr, odbz, nb, lat, both, tmo);
    compared++;
    if (tmo || {oq, orr, odbz} !== {8'd15, 4'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL basic_195_13: got q=%0d r=%0d dbz=%b tmo=%b, want q=15 r=0 dbz=0",
               oq, orr, odbz, tmo);
    end
    compared++;
    if (lat != 8 || nb != 8 || both) begin
      mismatched++;
      $display("FAIL basic_timing: got lat=%0d busy_cycles=%0d overlap=%b, want 8 8 0",
               lat, nb, both);
    end
    @(negedge clk);
    compared++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL done_one_cycle: got done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oq; logic [3:0] orr; logic odbz; int nb, lat; bit both, tmo;
    do_div(8'd200, 4'd7, oq, orr, odbz, nb, lat, both, tmo);
    compared++;
    if (tmo || {oq, orr, odbz} !== {8'd28, 4'd4, 1'b0}) begin
      mismatched++;
      $display("FAIL b2b_first: got q=%0d r=%0d dbz=%b, want q=28 r=4 dbz=0", oq, orr, odbz);
    end
    // Next request issued in the done cycle.
    do_div(8'd255, 4'd1, oq, orr, odbz, nb, lat, both, tmo);
    compared++;
    if (tmo || {oq, orr, odbz} !== {8'd255, 4'd0, 1'b0} || lat != 8 || both) begin
      mismatched++;
      $display("FAIL b2b_second: got q=%0d r=%0d dbz=%b lat=%0d, want q=255 r=0 dbz=0 lat=8",
               oq, orr, odbz, lat);
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    logic [7:0] oq; logic [3:0] orr; logic odbz; int nb, lat; bit both, tmo;
    do_div(8'd100, 4'd0, oq, orr, odbz, nb, lat, both, tmo);
    compared++;
    if (tmo || {oq, orr, odbz} !== {8'd255, 4'd0, 1'b1} || lat != 0 || nb != 0) begin
      mismatched++;
      $display("FAIL div_zero: got q=%0d r=%0d dbz=%b lat=%0d busy_cycles=%0d, want 255 0 1 0 0",
               oq, orr, odbz, lat, nb);
    end
    @(negedge clk);
    do_div(8'd9, 4'd3, oq, orr, odbz, nb, lat, both, tmo);
    compared++;
    if (tmo || {oq, orr, odbz} !== {8'd3, 4'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL after_dbz: got q=%0d r=%0d dbz=%b, want q=3 r=0 dbz=0", oq, orr, odbz);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [7:0] oq = '0;
    logic [3:0] orr = '0;
    logic odbz = 1'b1;
    x = 8'd50;
    y = 4'd5;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        x = 8'd1;
        y = 4'd1;
        start = 1'b1;
      end else if (i == 4) begin
        start = 1'b0;
        x = 8'd77;
        y = 4'd2;
      end
      if (done) begin
        pulses++;
        oq = q;
        orr = r;
        odbz = dbz;
      end
      @(negedge clk);
    end
    compared++;
    if (pulses != 1 || {oq, orr, odbz} !== {8'd10, 4'd0, 1'b0}) begin
      mismatched++;
      $display("FAIL ignore_start: got pulses=%0d q=%0d r=%0d dbz=%b, want 1 10 0 0",
               pulses, oq, orr, odbz);
    end
  endtask

  task automatic test_abort();
    logic [7:0] oq; logic [3:0] orr; logic odbz; int nb, lat; bit both, tmo;
    int pulses = 0;
    x = 8'd240;
    y = 4'd15;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({busy, done, q, r, dbz} !== 15'd0) begin
      mismatched++;
      $display("FAIL abort_reset: got busy=%b done=%b q=%0d r=%0d dbz=%b, want all 0",
               busy, done, q, r, dbz);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("FAIL abort_no_done: got %0d active cycles, want 0", pulses);
    end
    do_div(8'd17, 4'd4, oq, orr, odbz, nb, lat, both, tmo);
    compared++;
    if (tmo || {oq, orr, odbz} !== {8'd4, 4'd1, 1'b0}) begin
      mismatched++;
      $display("FAIL after_abort: got q=%0d r=%0d dbz=%b, want q=4 r=1 dbz=0", oq, orr, odbz);
    end
    @(negedge clk);
  endtask

  task automatic test_roundtrip();
    logic [7:0] oq; logic [3:0] orr; logic odbz; int nb, lat; bit both, tmo;
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        do_div(8'(a * b), 4'(b), oq, orr, odbz, nb, lat, both, tmo);
        compared++;
        if (tmo || oq !== 8'(a) || orr !== 4'd0 || odbz !== 1'b0 || lat != 8 || both) begin
          mismatched++;
          $display("FAIL roundtrip %0d*%0d: got q=%0d r=%0d dbz=%b lat=%0d, want q=%0d r=0",
                   a, b, oq, orr, odbz, lat, a);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] oq; logic [3:0] orr; logic odbz; int nb, lat; bit both, tmo;
    logic [7:0] a;
    logic [3:0] b;
    for (int i = 0; i < 300; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(1, 15));
      do_div(a, b, oq, orr, odbz, nb, lat, both, tmo);
      compared++;
      if (tmo || oq !== ref_q(a, b) || orr !== ref_r(a, b) || odbz !== 1'b0) begin
        mismatched++;
        $display("FAIL random %0d/%0d: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=0",
                 a, b, oq, orr, odbz, ref_q(a, b), ref_r(a, b));
      end
      // Alternate back-to-back and spaced requests.
      if (i % 2 == 0) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_abort();
    test_roundtrip();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
